// File: rtl/profile_pkg.sv
// Shared types for the multi-channel profile counter.
// Holds the channel FSM state and the read-select width helper.
package profile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter_profile_mc_if.sv
// Shadow read port of the profile counter.
// Request/select from the master, one-cycle-later data back.
interface counter_profile_mc_if #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 2
) ();

  logic             rd_req;
  logic [SEL_W-1:0] rd_sel;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ovf;

  modport master (
    output rd_req,
    output rd_sel,
    input  rd_valid,
    input  rd_data,
    input  rd_ovf
  );

  modport slave (
    input  rd_req,
    input  rd_sel,
    output rd_valid,
    output rd_data,
    output rd_ovf
  );

endinterface

// File: rtl/profile_channel.sv
// One profile channel: IDLE/RUN/HALT FSM, counter, sticky overflow.
// The start cycle counts, the stop cycle does not.
module profile_channel
  import profile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             running
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_nx;
  logic   inc;
  logic   at_max;

  assign inc    = (state == RUN || start) && en && !stop && !clear;
  assign at_max = &count;

  // Next state, clear beats stop beats start.
  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = IDLE;
    end else if (stop) begin
      if (state == RUN) state_nx = HALT;
    end else if (start) begin
      state_nx = RUN;
    end
  end

  // State, registered running flag, count and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      running <= 1'b0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nx;
      running <= (state_nx == RUN);
      if (clear) begin
        count <= '0;
        ovf   <= 1'b0;
      end else if (inc) begin
        if (at_max) begin
          ovf   <= 1'b1;
          count <= (SATURATE != 0) ? count : '0;
        end else begin
          count <= count + ONE;
        end
      end
    end
  end

endmodule

// File: rtl/counter_profile_mc.sv
// Multi-channel profile counter with snapshot shadows.
// Reads return shadow[rd_sel] one cycle after rd_req.
module counter_profile_mc
  import profile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] clear,
  input  logic                snap,
  counter_profile_mc_if.slave rd,
  output logic [CHANNELS-1:0] running,
  output logic [CHANNELS-1:0] overflow
);

  localparam int SEL_W = sel_width(CHANNELS);
  localparam logic [SEL_W:0] CH_LIM = CHANNELS[SEL_W:0];

  logic [WIDTH-1:0]    cnt    [CHANNELS];
  logic [WIDTH-1:0]    sh_cnt [CHANNELS];
  logic [CHANNELS-1:0] sh_ovf;
  logic                sel_ok;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    profile_channel #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .start   (start[i]),
      .stop    (stop[i]),
      .en      (en[i]),
      .clear   (clear[i]),
      .count   (cnt[i]),
      .ovf     (overflow[i]),
      .running (running[i])
    );
  end

  assign sel_ok = ({1'b0, rd.rd_sel} < CH_LIM);

  // Snapshot takes the pre-edge counts of every channel at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) sh_cnt[i] <= '0;
      sh_ovf <= '0;
    end else if (snap) begin
      for (int i = 0; i < CHANNELS; i++) sh_cnt[i] <= cnt[i];
      sh_ovf <= overflow;
    end
  end

  // Read mux; sees the pre-snap shadow on a same-cycle snap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd.rd_valid <= 1'b0;
      rd.rd_data  <= '0;
      rd.rd_ovf   <= 1'b0;
    end else begin
      rd.rd_valid <= rd.rd_req;
      if (rd.rd_req) begin
        if (sel_ok) begin
          rd.rd_data <= sh_cnt[rd.rd_sel];
          rd.rd_ovf  <= sh_ovf[rd.rd_sel];
        end else begin
          rd.rd_data <= '0;
          rd.rd_ovf  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_profile_mc.sv
// Bench for counter_profile_mc: wrap and saturate builds side by side.
// Expected reads are queued at request time and popped at rd_valid.
module tb_counter_profile_mc;

  localparam int W  = 8;
  localparam int CH = 3;
  localparam int SW = 2;

  logic          clk;
  logic          reset;
  logic          snap;
  logic [CH-1:0] start, stop, en, clear;
  logic [CH-1:0] running0, overflow0;
  logic [CH-1:0] running1, overflow1;

  logic [19:0] q[$];
  logic [19:0] got, want;
  int total = 0;
  int bad   = 0;

  counter_profile_mc_if #(.WIDTH(W), .SEL_W(SW)) rd0 ();
  counter_profile_mc_if #(.WIDTH(W), .SEL_W(SW)) rd1 ();

  counter_profile_mc #(.WIDTH(W), .CHANNELS(CH), .SATURATE(0)) dut0 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .en       (en),
    .clear    (clear),
    .snap     (snap),
    .rd       (rd0.slave),
    .running  (running0),
    .overflow (overflow0)
  );

  counter_profile_mc #(.WIDTH(W), .CHANNELS(CH), .SATURATE(1)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .en       (en),
    .clear    (clear),
    .snap     (snap),
    .rd       (rd1.slave),
    .running  (running1),
    .overflow (overflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] obs();
    return {rd0.rd_valid, rd0.rd_ovf, rd0.rd_data,
            rd1.rd_valid, rd1.rd_ovf, rd1.rd_data};
  endfunction

  function automatic logic [19:0] exp_rd(input logic o0, input logic [7:0] d0,
                                         input logic o1, input logic [7:0] d1);
    return {1'b1, o0, d0, 1'b1, o1, d1};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input logic [SW-1:0] sel, input logic req);
    rd0.rd_req = req;
    rd1.rd_req = req;
    rd0.rd_sel = sel;
    rd1.rd_sel = sel;
  endtask

  task automatic issue_read(input logic [SW-1:0] sel, input logic sn);
    set_req(sel, 1'b1);
    snap = sn;
    tick(1);
    set_req(sel, 1'b0);
    snap = 1'b0;
  endtask

  task automatic do_snap();
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    snap  = 1'b0;
    start = '0;
    stop  = '0;
    en    = '0;
    clear = '0;
    set_req('0, 1'b0);
    tick(2);
    total++;
    if ({running0, overflow0, running1, overflow1, obs()} !== 32'd0) begin
      bad++;
      $display("FAIL reset_state got=%h want=0",
               {running0, overflow0, running1, overflow1, obs()});
    end
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_run_stop();
    en = 3'b111;
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    total++;
    if ({running0, running1} !== 6'b001_001) begin
      bad++;
      $display("FAIL run_running got=%b want=001001", {running0, running1});
    end
    tick(9);
    stop[0] = 1'b1;
    tick(1);
    stop[0] = 1'b0;
    total++;
    if ({running0, running1} !== 6'b000_000) begin
      bad++;
      $display("FAIL stop_running got=%b want=000000", {running0, running1});
    end
    tick(5);
    do_snap();
    q.push_back(exp_rd(1'b0, 8'd10, 1'b0, 8'd10));
    issue_read(2'd0, 1'b0);
    want = q.pop_front();
    got  = obs();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL ch0_hold got=%h want=%h", got, want);
    end
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    stop[0]  = 1'b1;
    tick(1);
    stop[0]  = 1'b0;
    do_snap();
    q.push_back(exp_rd(1'b0, 8'd11, 1'b0, 8'd11));
    issue_read(2'd0, 1'b0);
    want = q.pop_front();
    got  = obs();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL ch0_resume got=%h want=%h", got, want);
    end
  endtask

  task automatic test_start_stop_same();
    start[1] = 1'b1;
    stop[1]  = 1'b1;
    tick(1);
    start[1] = 1'b0;
    stop[1]  = 1'b0;
    total++;
    if ({running0, running1} !== 6'b000_000) begin
      bad++;
      $display("FAIL ss_idle_running got=%b want=000000", {running0, running1});
    end
    do_snap();
    q.push_back(exp_rd(1'b0, 8'd0, 1'b0, 8'd0));
    issue_read(2'd1, 1'b0);
    want = q.pop_front();
    got  = obs();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL ss_idle_count got=%h want=%h", got, want);
    end
    start[1] = 1'b1;
    tick(1);
    start[1] = 1'b0;
    tick(2);
    start[1] = 1'b1;
    stop[1]  = 1'b1;
    tick(1);
    start[1] = 1'b0;
    stop[1]  = 1'b0;
    total++;
    if ({running0, running1} !== 6'b000_000) begin
      bad++;
      $display("FAIL ss_run_running got=%b want=000000", {running0, running1});
    end
    do_snap();
    q.push_back(exp_rd(1'b0, 8'd3, 1'b0, 8'd3));
    issue_read(2'd1, 1'b0);
    want = q.pop_front();
    got  = obs();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL ss_run_count got=%h want=%h", got, want);
    end
  endtask

  task automatic test_overflow();
    start[2] = 1'b1;
    tick(1);
    start[2] = 1'b0;
    tick(256);
    stop[2] = 1'b1;
    tick(1);
    stop[2] = 1'b0;
    total++;
    if ({overflow0, overflow1} !== 6'b100_100) begin
      bad++;
      $display("FAIL ovf_flag got=%b want=100100", {overflow0, overflow1});
    end
    do_snap();
    q.push_back(exp_rd(1'b1, 8'd1, 1'b1, 8'd255));
    issue_read(2'd2, 1'b0);
    want = q.pop_front();
    got  = obs();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL ovf_count got=%h want=%h", got, want);
    end
    clear[2] = 1'b1;
    tick(1);
    clear[2] = 1'b0;
    total++;
    if ({overflow0, overflow1} !== 6'b000_000) begin
      bad++;
      $display("FAIL clr_flag got=%b want=000000", {overflow0, overflow1});
    end
    do_snap();
    q.push_back(exp_rd(1'b0, 8'd0, 1'b0, 8'd0));
    issue_read(2'd2, 1'b0);
    want = q.pop_front();
    got  = obs();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL clr_count got=%h want=%h", got, want);
    end
  endtask

  task automatic test_snap_read();
    start[2] = 1'b1;
    tick(1);
    start[2] = 1'b0;
    tick(6);
    q.push_back(exp_rd(1'b0, 8'd0, 1'b0, 8'd0));
    issue_read(2'd2, 1'b1);
    want = q.pop_front();
    got  = obs();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL snap_rd_same got=%h want=%h", got, want);
    end
    q.push_back(exp_rd(1'b0, 8'd7, 1'b0, 8'd7));
    issue_read(2'd2, 1'b0);
    want = q.pop_front();
    got  = obs();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL snap_rd_next got=%h want=%h", got, want);
    end
    stop[2] = 1'b1;
    do_snap();
    stop[2] = 1'b0;
    q.push_back(exp_rd(1'b0, 8'd9, 1'b0, 8'd9));
    issue_read(2'd2, 1'b0);
    want = q.pop_front();
    got  = obs();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL snap_live got=%h want=%h", got, want);
    end
  endtask

  task automatic test_en_toggle();
    clear[1] = 1'b1;
    tick(1);
    clear[1] = 1'b0;
    start[1] = 1'b1;
    en[1]    = 1'b1;
    tick(1);
    start[1] = 1'b0;
    en[1]    = 1'b0;
    tick(1);
    en[1]    = 1'b1;
    tick(1);
    en[1]    = 1'b0;
    tick(1);
    stop[1]  = 1'b1;
    tick(1);
    stop[1]  = 1'b0;
    en       = 3'b111;
    do_snap();
    q.push_back(exp_rd(1'b0, 8'd2, 1'b0, 8'd2));
    issue_read(2'd1, 1'b0);
    want = q.pop_front();
    got  = obs();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL en_toggle got=%h want=%h", got, want);
    end
    q.push_back(exp_rd(1'b0, 8'd0, 1'b0, 8'd0));
    issue_read(2'd3, 1'b0);
    want = q.pop_front();
    got  = obs();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL sel_range got=%h want=%h", got, want);
    end
  endtask

  task automatic test_async_reset();
    start = 3'b011;
    tick(1);
    start = '0;
    total++;
    if ({running0, running1} !== 6'b011_011) begin
      bad++;
      $display("FAIL ar_running got=%b want=011011", {running0, running1});
    end
    set_req(2'd0, 1'b1);
    @(posedge clk);
    #2;
    set_req(2'd0, 1'b0);
    total++;
    if (obs() !== exp_rd(1'b0, 8'd11, 1'b0, 8'd11)) begin
      bad++;
      $display("FAIL ar_pre_read got=%h want=%h",
               obs(), exp_rd(1'b0, 8'd11, 1'b0, 8'd11));
    end
    reset = 1'b0;
    #1;
    total++;
    if ({running0, overflow0, running1, overflow1, obs()} !== 32'd0) begin
      bad++;
      $display("FAIL ar_async got=%h want=0",
               {running0, overflow0, running1, overflow1, obs()});
    end
    @(negedge clk);
    reset = 1'b1;
    tick(3);
    total++;
    if ({running0, running1} !== 6'b000_000) begin
      bad++;
      $display("FAIL ar_post_running got=%b want=000000", {running0, running1});
    end
    do_snap();
    for (int c = 0; c < 2; c++) begin
      q.push_back(exp_rd(1'b0, 8'd0, 1'b0, 8'd0));
      issue_read(SW'(c), 1'b0);
      want = q.pop_front();
      got  = obs();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL ar_count%0d got=%h want=%h", c, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_stop();
    test_start_stop_same();
    test_overflow();
    test_snap_read();
    test_en_toggle();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
